// File: rtl/video_rank_filter.sv
// 3x3 rank-order filter (median / min / max / bypass) per colour channel with internal line buffers.
// Four register stages; sideband timing travels through the same four stages so de_out marks data_out.
module video_rank_filter #(
    parameter int DW    = 8,
    parameter int CH    = 3,
    parameter int H_MAX = 2048,
    parameter int CW    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [CH*DW-1:0] data_in,
    input  logic             rgb_hs,
    input  logic             rgb_vs,
    input  logic             rgb_de,
    input  logic [CW-1:0]    h_cnt,
    input  logic [CW-1:0]    v_cnt,
    output logic [CH*DW-1:0] data_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic             de_out,
    output logic [CW-1:0]    h_cnt_out,
    output logic [CW-1:0]    v_cnt_out
);
    localparam int            AW       = (H_MAX > 1) ? $clog2(H_MAX) : 1;
    localparam logic [AW-1:0] COL_LAST = AW'(H_MAX - 1);
    localparam int            SBW      = 3 + 2 * CW;

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DW-1:0] min3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [DW-1:0] max3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic [AW-1:0] col;
    logic          col_full;
    logic [1:0]    row;
    logic [1:0]    mode_q;
    logic          de_q;
    logic          vs_q;

    logic          vs_rise;
    logic          de_fall;
    logic          wr_en;
    logic [1:0]    row_eff;
    logic [1:0]    mode_eff;
    logic          border;

    // A vs rising edge applies to the pixel arriving with it: row 0, new mode.
    always_comb begin
        vs_rise  = rgb_vs & ~vs_q;
        de_fall  = ~rgb_de & de_q;
        row_eff  = vs_rise ? 2'd0 : row;
        mode_eff = vs_rise ? mode : mode_q;
        wr_en    = rgb_de & ~col_full;
        border   = ~rgb_de | col_full | (col < AW'(2)) | (row_eff < 2'd2) | (mode_eff == 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            col_full <= 1'b0;
            row      <= 2'd0;
            mode_q   <= 2'd1;
            de_q     <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            de_q <= rgb_de;
            vs_q <= rgb_vs;
            if (vs_rise) begin
                mode_q <= mode;
            end
            if (rgb_de) begin
                if (col == COL_LAST) begin
                    col_full <= 1'b1;
                end else begin
                    col <= col + AW'(1);
                end
            end else if (de_q) begin
                col      <= '0;
                col_full <= 1'b0;
            end
            if (vs_rise) begin
                row <= 2'd0;
            end else if (de_fall && row != 2'd2) begin
                row <= row + 2'd1;
            end
        end
    end

    logic [SBW-1:0]     sb       [4];
    logic [1:0]         mode_p   [3];
    logic               border_p [3];
    logic [CH*DW-1:0]   centre_p [3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                sb[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                mode_p[i]   <= 2'd0;
                border_p[i] <= 1'b0;
                centre_p[i] <= '0;
            end
        end else begin
            sb[0]       <= {rgb_hs, rgb_vs, rgb_de, h_cnt, v_cnt};
            mode_p[0]   <= mode_eff;
            border_p[0] <= border;
            centre_p[0] <= data_in;
            for (int i = 1; i < 4; i++) begin
                sb[i] <= sb[i-1];
            end
            for (int i = 1; i < 3; i++) begin
                mode_p[i]   <= mode_p[i-1];
                border_p[i] <= border_p[i-1];
                centre_p[i] <= centre_p[i-1];
            end
        end
    end

    assign {hs_out, vs_out, de_out, h_cnt_out, v_cnt_out} = sb[3];

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [DW-1:0] lb0 [H_MAX];
        logic [DW-1:0] lb1 [H_MAX];
        logic [DW-1:0] pix;
        logic [DW-1:0] top;
        logic [DW-1:0] mid;
        // win[line][column]: line 0 is two lines up, column 2 is the newest pixel
        logic [DW-1:0] win [3][3];
        logic [DW-1:0] lo [3];
        logic [DW-1:0] md [3];
        logic [DW-1:0] hi [3];
        logic [DW-1:0] max_lo, med_md, min_hi, min_all, max_all;
        logic [DW-1:0] res;

        assign pix = data_in[k*DW +: DW];
        assign top = lb0[col];
        assign mid = lb1[col];

        always_ff @(posedge clk) begin
            if (wr_en) begin
                lb1[col] <= pix;
                lb0[col] <= mid;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        win[r][c] <= '0;
                    end
                    lo[r] <= '0;
                    md[r] <= '0;
                    hi[r] <= '0;
                end
                max_lo  <= '0;
                med_md  <= '0;
                min_hi  <= '0;
                min_all <= '0;
                max_all <= '0;
                res     <= '0;
            end else begin
                if (rgb_de) begin
                    for (int r = 0; r < 3; r++) begin
                        win[r][0] <= win[r][1];
                        win[r][1] <= win[r][2];
                    end
                    win[0][2] <= top;
                    win[1][2] <= mid;
                    win[2][2] <= pix;
                end
                for (int c = 0; c < 3; c++) begin
                    lo[c] <= min3(win[0][c], win[1][c], win[2][c]);
                    md[c] <= med3(win[0][c], win[1][c], win[2][c]);
                    hi[c] <= max3(win[0][c], win[1][c], win[2][c]);
                end
                max_lo  <= max3(lo[0], lo[1], lo[2]);
                med_md  <= med3(md[0], md[1], md[2]);
                min_hi  <= min3(hi[0], hi[1], hi[2]);
                min_all <= min3(lo[0], lo[1], lo[2]);
                max_all <= max3(hi[0], hi[1], hi[2]);
                if (border_p[2]) begin
                    res <= centre_p[2][k*DW +: DW];
                end else begin
                    case (mode_p[2])
                        2'd2:    res <= min_all;
                        2'd3:    res <= max_all;
                        default: res <= med3(max_lo, med_md, min_hi);
                    endcase
                end
            end
        end

        assign data_out[k*DW +: DW] = res;
    end

endmodule
